// File: rtl/duck_rom_arbiter.sv
// duck_rom_arbiter
//   Round-robin arbiter letting NUM_REQ duck renderers share one sprite ROM.
//   A grant (combinational, one-hot) launches a two-stage read:
//     stage 1: register {frame, addr} onto rom_address
//     stage 2: the ROM (clocked on ~vga_clk) has produced rom_q by then; capture it
//   The response appears two cycles after the grant, tagged with the requester id.
//
// Ports
//   vga_clk, reset_n      clock, async active-low reset
//   arb_en                grants permitted while high
//   req[NUM_REQ]          level requests
//   req_addr, req_frame   flattened per-requester address / frame slices
//   gnt[NUM_REQ]          one-hot grant (combinational)
//   rom_address           registered {frame, addr} to the ROM
//   rom_q                 ROM read data
//   rsp_valid/id/data     response strobe, owner, palette index
//   busy                  a read is in stage 1 or stage 2
//   gnt_count             per-requester saturating grant counters
//                         (only with DUCK_ROM_ARB_STATS_EN defined)
module duck_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int FRAME_W = 2,
  parameter int DATA_W  = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [FRAME_W+ADDR_W-1:0]  rom_address,
  input  logic [DATA_W-1:0]          rom_q,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
`ifdef DUCK_ROM_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]      gnt_count,
`endif
  output logic                       busy
);

  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_arr;
  logic [NUM_REQ-1:0][FRAME_W-1:0] frame_arr;
  assign addr_arr  = req_addr;
  assign frame_arr = req_frame;

  logic [ID_W-1:0] last_gnt;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic [2:1]      vld_pipe;   // [1] = stage 1 occupied, [2] = response valid
  logic [ID_W-1:0] s1_id;

  // Round-robin search starting one past the last winner. Grants are also
  // suppressed combinationally while in reset.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    gnt     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_gnt) + k) % NUM_REQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
    if (!arb_en || !reset_n) win_vld = 1'b0;
    if (win_vld) gnt[win_id] = 1'b1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt    <= ID_W'(NUM_REQ - 1);
      rom_address <= '0;
      s1_id       <= '0;
      vld_pipe    <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], win_vld};
      if (win_vld) begin
        last_gnt    <= win_id;
        rom_address <= {frame_arr[win_id], addr_arr[win_id]};
        s1_id       <= win_id;
      end
      // rom_q was produced on the falling edge inside this cycle from the
      // address registered at the previous edge.
      if (vld_pipe[1]) begin
        rsp_id   <= s1_id;
        rsp_data <= rom_q;
      end
    end
  end

  assign rsp_valid = vld_pipe[2];
  assign busy      = vld_pipe[1] | vld_pipe[2];

`ifdef DUCK_ROM_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n)                    cnt_q[g] <= '0;
      else if (gnt[g] && cnt_q[g] != 16'hFFFF) cnt_q[g] <= cnt_q[g] + 16'd1;
    end
  end

  assign gnt_count = cnt_q;
`endif

endmodule
